// File: rtl/icache_refill_ctrl.sv
// Icache refill controller: fetches one line from memory on a miss and writes its beats into
// the single-port data SRAM, arbitrating the port against fetch-side reads (writes win).
module icache_refill_ctrl #(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned NUM_WORDS      = 1024,
    parameter int unsigned ADDR_WIDTH     = $clog2(NUM_WORDS),
    parameter int unsigned BEATS_PER_LINE = 4,
    parameter int unsigned MEM_ADDR_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      miss_valid_i,
    output logic                      miss_ready_o,
    input  logic [MEM_ADDR_WIDTH-1:0] miss_addr_i,
    output logic                      refill_done_o,
    output logic                      mem_req_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                      mem_gnt_i,
    input  logic                      mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
    input  logic                      rd_req_i,
    input  logic [ADDR_WIDTH-1:0]     rd_addr_i,
    output logic                      rd_stall_o,
    output logic                      sram_req_o,
    output logic                      sram_we_o,
    output logic [ADDR_WIDTH-1:0]     sram_addr_o,
    output logic [DATA_WIDTH-1:0]     sram_wdata_o
);

    localparam int unsigned OFF = $clog2(DATA_WIDTH / 8);
    localparam int unsigned BB  = $clog2(BEATS_PER_LINE);

    localparam logic [MEM_ADDR_WIDTH-1:0] LineMask = {MEM_ADDR_WIDTH{1'b1}} << (OFF + BB);
    localparam logic [BB-1:0]             LastBeat = BB'(BEATS_PER_LINE - 1);

    typedef enum logic [1:0] {StIdle, StReq, StData, StDone} state_e;

    state_e                      state_q;
    logic [BB-1:0]               cnt_q;
    logic [MEM_ADDR_WIDTH-1:0]   addr_q;
    logic                        miss_ready_q;
    logic                        mem_req_q;
    logic                        done_q;
    logic                        wr_beat;

    // miss_ready_q stays low for the first cycle after reset so all outputs read 0 until then.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            addr_q       <= '0;
            miss_ready_q <= 1'b0;
            mem_req_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    miss_ready_q <= 1'b1;
                    if (miss_valid_i && miss_ready_q) begin
                        addr_q       <= miss_addr_i & LineMask;
                        mem_req_q    <= 1'b1;
                        miss_ready_q <= 1'b0;
                        state_q      <= StReq;
                    end
                end
                StReq: begin
                    if (mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= StData;
                    end
                end
                StData: begin
                    if (mem_rvalid_i) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LastBeat) begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    done_q       <= 1'b0;
                    miss_ready_q <= 1'b1;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign wr_beat       = (state_q == StData) && mem_rvalid_i;
    assign miss_ready_o  = miss_ready_q;
    assign refill_done_o = done_q;
    assign mem_req_o     = mem_req_q;
    assign mem_addr_o    = mem_req_q ? addr_q : '0;

    always_comb begin
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        rd_stall_o   = 1'b0;
        if (wr_beat) begin
            sram_req_o   = 1'b1;
            sram_we_o    = 1'b1;
            sram_addr_o  = {addr_q[OFF+ADDR_WIDTH-1:OFF+BB], cnt_q};
            sram_wdata_o = mem_rdata_i;
            rd_stall_o   = rd_req_i;
        end else if (rd_req_i) begin
            sram_req_o  = 1'b1;
            sram_addr_o = rd_addr_i;
        end
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl: drivers push expected SRAM writes, a negedge monitor
// pops and compares them along with per-cycle port, stall and done expectations.
module tb_icache_refill_ctrl;

    localparam int unsigned DW    = 64;
    localparam int unsigned NW    = 1024;
    localparam int unsigned AW    = 10;
    localparam int unsigned BEATS = 4;
    localparam int unsigned MAW   = 32;
    localparam int unsigned LINE_BYTES = BEATS * DW / 8;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic           miss_valid_i, miss_ready_o, refill_done_o;
    logic [MAW-1:0] miss_addr_i, mem_addr_o;
    logic           mem_req_o, mem_gnt_i, mem_rvalid_i;
    logic [DW-1:0]  mem_rdata_i, sram_wdata_o;
    logic           rd_req_i, rd_stall_o, sram_req_o, sram_we_o;
    logic [AW-1:0]  rd_addr_i, sram_addr_o;

    icache_refill_ctrl dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .miss_valid_i (miss_valid_i),
        .miss_ready_o (miss_ready_o),
        .miss_addr_i  (miss_addr_i),
        .refill_done_o(refill_done_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .rd_req_i     (rd_req_i),
        .rd_addr_i    (rd_addr_i),
        .rd_stall_o   (rd_stall_o),
        .sram_req_o   (sram_req_o),
        .sram_we_o    (sram_we_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wdata_o (sram_wdata_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t      exp_q[$];
    int       checks = 0;
    int       errors = 0;
    int       cyc = 0;
    int       done_due = -10;
    int       rd_mode = 0;
    bit       mon_en = 0;
    bit       exp_write = 0;
    bit       exp_mem_req = 0;
    logic [MAW-1:0] exp_line = '0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle the expected port behaviour is derived from what the drivers issued.
    always @(negedge clk_i) begin
        if (mon_en) begin
            chk("sram_we", 64'(sram_we_o), 64'(exp_write));
            if (exp_write) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 64'(sram_we_o), 64'd0);
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    chk("wr_req", 64'(sram_req_o), 64'd1);
                    chk("wr_addr", 64'(sram_addr_o), 64'(w.addr));
                    chk("wr_data", 64'(sram_wdata_o), 64'(w.data));
                end
            end else begin
                chk("idle_wdata", 64'(sram_wdata_o), 64'd0);
            end
            if (rd_req_i) begin
                chk("rd_stall", 64'(rd_stall_o), 64'(exp_write));
                if (!exp_write) begin
                    chk("rd_req", 64'(sram_req_o), 64'd1);
                    chk("rd_addr", 64'(sram_addr_o), 64'(rd_addr_i));
                end
            end else begin
                chk("stall_idle", 64'(rd_stall_o), 64'd0);
                if (!exp_write) begin
                    chk("sram_req_idle", 64'(sram_req_o), 64'd0);
                    chk("sram_addr_idle", 64'(sram_addr_o), 64'd0);
                end
            end
            chk("mem_req", 64'(mem_req_o), 64'(exp_mem_req));
            chk("mem_addr", 64'(mem_addr_o), exp_mem_req ? 64'(exp_line) : 64'd0);
            chk("refill_done", 64'(refill_done_o), 64'(cyc == done_due));
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
        if (rd_mode == 2) begin
            rd_req_i  = 1'($urandom_range(0, 1));
            rd_addr_i = AW'($urandom);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, 64'(miss_ready_o), 64'd0);
        chk({tag, "_done"}, 64'(refill_done_o), 64'd0);
        chk({tag, "_memreq"}, 64'(mem_req_o), 64'd0);
        chk({tag, "_memaddr"}, 64'(mem_addr_o), 64'd0);
        chk({tag, "_sreq"}, 64'(sram_req_o), 64'd0);
        chk({tag, "_swe"}, 64'(sram_we_o), 64'd0);
        chk({tag, "_saddr"}, 64'(sram_addr_o), 64'd0);
        chk({tag, "_swdata"}, 64'(sram_wdata_o), 64'd0);
        chk({tag, "_stall"}, 64'(rd_stall_o), 64'd0);
    endtask

    // One line refill. abort_at >= 0 resets the DUT just before that beat would be driven.
    task automatic refill(input logic [MAW-1:0] a, input int gnt_dly, input int gap,
                          input bit stray, input int abort_at, input bit hold_next,
                          input logic [MAW-1:0] next_a);
        int n;
        logic [AW-1:0] base;
        exp_line     = a & ~MAW'(LINE_BYTES - 1);
        base         = AW'((exp_line / (DW / 8)) % NW);
        miss_valid_i = 1'b1;
        miss_addr_i  = a;
        n = 0;
        while (!miss_ready_o && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("miss_ready_timeout", 64'(miss_ready_o), 64'd1);
        tick();
        if (hold_next) miss_addr_i = next_a;
        else miss_valid_i = 1'b0;
        exp_mem_req = 1'b1;
        for (int i = 0; i < gnt_dly; i++) begin
            mem_rvalid_i = stray;
            mem_rdata_i  = {$urandom, $urandom};
            tick();
        end
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = stray;
        tick();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        exp_mem_req  = 1'b0;
        for (int b = 0; b < int'(BEATS); b++) begin
            for (int g = 0; g < gap; g++) begin
                mem_rvalid_i = 1'b0;
                exp_write    = 1'b0;
                tick();
            end
            if (b == abort_at) begin
                mem_rvalid_i = 1'b0;
                exp_write    = 1'b0;
                miss_valid_i = 1'b0;
                @(negedge clk_i);
                mon_en = 0;
                #2 rst_ni = 1'b0;
                #1 check_all_zero("abort_rst");
                exp_q.delete();
                done_due = -10;
                @(negedge clk_i);
                rst_ni = 1'b1;
                tick();
                chk("ready_after_abort", 64'(miss_ready_o), 64'd1);
                mon_en = 1;
                return;
            end
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = {$urandom, $urandom};
            exp_write    = 1'b1;
            exp_q.push_back('{addr: base + AW'(b), data: mem_rdata_i});
            if (b == int'(BEATS) - 1) done_due = cyc + 1;
            tick();
        end
        mem_rvalid_i = 1'b0;
        exp_write    = 1'b0;
        chk("ready_low_in_done", 64'(miss_ready_o), 64'd0);
        tick();
        chk("ready_after_done", 64'(miss_ready_o), 64'd1);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst_ni       = 1'b0;
        miss_valid_i = 1'b0;
        miss_addr_i  = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        rd_req_i     = 1'b0;
        rd_addr_i    = '0;
        #3 check_all_zero("por");
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        chk("ready_after_reset", 64'(miss_ready_o), 64'd1);
        mon_en = 1;

        refill(32'h0000_1A38, 3, 0, 0, -1, 0, '0);
        refill(MAW'($urandom), 1, 2, 0, -1, 0, '0);

        rd_mode = 1;
        rd_req_i  = 1'b1;
        rd_addr_i = AW'(10'h010);
        refill(MAW'($urandom), 2, 1, 0, -1, 0, '0);
        rd_mode  = 0;
        rd_req_i = 1'b0;

        refill(MAW'($urandom), 1, 0, 0, 2, 0, '0);
        refill(32'h0000_0000, 1, 0, 0, -1, 0, '0);

        refill(32'h0000_4F10, 2, 0, 1, -1, 1, 32'h0000_8008);
        refill(32'h0000_8008, 0, 0, 1, -1, 0, '0);

        rd_mode = 2;
        for (int k = 0; k < 20; k++) begin
            refill(MAW'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                   1'($urandom_range(0, 1)), -1, 0, '0);
        end
        rd_mode  = 0;
        rd_req_i = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
